// File: rtl/bit_diff_sched_if.sv
// bit_diff_sched_if: requester, response and engine signals of the bit-difference scheduler.
// Latency: none, wiring only.
// Backpressure: requesters hold req until gnt; the engine reports completion with a sticky done.
// Modports: master = scheduler side (drives gnt/resp/eng_go/eng_data),
//           slave  = requesters plus engine side (drives req/req_data/eng_result/eng_done).
interface bit_diff_sched_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int RW = $clog2(2*WIDTH+1);
  localparam int IW = $clog2(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       gnt;
  logic               resp_valid;
  logic [IW-1:0]      resp_id;
  logic [RW-1:0]      resp_result;
  logic               resp_err;
  logic               busy;
  logic               eng_go;
  logic [WIDTH-1:0]   eng_data;
  logic [RW-1:0]      eng_result;
  logic               eng_done;

  modport master (
    input  req, req_data, eng_result, eng_done,
    output gnt, resp_valid, resp_id, resp_result, resp_err, busy, eng_go, eng_data
  );

  modport slave (
    output req, req_data, eng_result, eng_done,
    input  gnt, resp_valid, resp_id, resp_result, resp_err, busy, eng_go, eng_data
  );
endinterface

// File: rtl/bit_diff_sched.sv
// bit_diff_sched: round-robin scheduler sharing one bit-difference engine among N requesters.
// Latency: gnt/eng_go 1 cycle after the request is sampled in IDLE, resp_valid at WIDTH+3 (TIMEOUT+2 on abort).
// Backpressure: one job in flight; other requesters keep req high and wait, no queueing.
// Ports: clk, rst (async, active-high), bus (master modport): req/req_data in, gnt out,
//        resp_valid/resp_id/resp_result/resp_err/busy out, eng_go/eng_data out, eng_result/eng_done in.
module bit_diff_sched #(
  parameter int N       = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  bit_diff_sched_if.master bus
);
  localparam int RW  = $clog2(2*WIDTH+1);
  localparam int IW  = $clog2(N);
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT-1);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   id_q;
  logic [IW-1:0]   winner;
  logic            found;
  logic [WIDTH-1:0] data_q;
  logic [WDW-1:0]  wd_cnt;
  logic [RW-1:0]   result_q;
  logic            err_q;

  // Scan ptr, ptr+1, ... mod N. Walking the offsets downwards lets the
  // smallest offset (first in scan order) overwrite any later candidate.
  always_comb begin : arb
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = N-1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (bus.req[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin : fsm_comb
    state_nxt       = state;
    bus.gnt         = '0;
    bus.eng_go      = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_id     = '0;
    bus.busy        = (state != IDLE);
    bus.eng_data    = data_q;
    bus.resp_result = result_q;
    bus.resp_err    = err_q;
    unique case (state)
      IDLE: begin
        if (found) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        bus.gnt    = N'(1) << id_q;
        bus.eng_go = 1'b1;
        state_nxt  = BUSY;
      end
      BUSY: begin
        if (bus.eng_done || wd_cnt == WD_LAST) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_id    = id_q;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      id_q     <= '0;
      data_q   <= '0;
      wd_cnt   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (found) begin
            id_q   <= winner;
            data_q <= bus.req_data[int'(winner)*WIDTH +: WIDTH];
            ptr    <= (winner == IW'(N-1)) ? '0 : winner + IW'(1);
            wd_cnt <= '0;
          end
        end
        LAUNCH: wd_cnt <= '0;
        BUSY: begin
          wd_cnt <= wd_cnt + WDW'(1);
          // A done arriving on the watchdog's last cycle still counts as success.
          if (bus.eng_done) begin
            result_q <= bus.eng_result;
            err_q    <= 1'b0;
          end else if (wd_cnt == WD_LAST) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_diff_sched.sv
// tb_bit_diff_sched: randomized and directed checks of bit_diff_sched against a job-timing model.
// Latency: model predicts gnt at t+1 and resp at t+WIDTH+3 (t+TIMEOUT+2 with a hung engine).
// Backpressure: requesters hold req until they see gnt, then drop it.
module tb_bit_diff_sched;
  localparam int N       = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int RW      = $clog2(2*WIDTH+1);
  localparam int IW      = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  bit   eng_hang;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  bit_diff_sched_if #(.N(N), .WIDTH(WIDTH)) bus ();

  bit_diff_sched #(.N(N), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- engine stand-in ----------------
  bit               go_s;
  logic [WIDTH-1:0] word_s;
  logic [WIDTH-1:0] e_word;
  int               e_cnt;
  bit               e_run;

  always @(negedge clk) begin
    go_s   = bus.eng_go;
    word_s = bus.eng_data;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.eng_done   <= 1'b0;
      bus.eng_result <= '0;
      e_run          <= 1'b0;
      e_cnt          <= 0;
      e_word         <= '0;
    end else if (go_s) begin
      bus.eng_done <= 1'b0;
      e_run        <= !eng_hang;
      e_cnt        <= WIDTH;
      e_word       <= word_s;
    end else if (e_run) begin
      e_cnt <= e_cnt - 1;
      if (e_cnt == 1) begin
        bus.eng_done   <= 1'b1;
        e_run          <= 1'b0;
        bus.eng_result <= RW'(2*$countones(e_word) - WIDTH);
      end
    end
  end

  // ---------------- job-level reference model + per-cycle compare ----------------
  bit               m_live;
  int               m_gnt_at, m_resp_at, m_id, m_ptr;
  logic [WIDTH-1:0] m_data;
  logic [RW-1:0]    m_res, job_res;
  logic             m_err, job_err;

  always @(negedge clk) begin
    logic [N-1:0] e_gnt;
    logic         e_rv, e_busy;
    cyc++;
    if (rst) begin
      m_live = 1'b0;
      m_ptr  = 0;
      m_data = '0;
      m_res  = '0;
      m_err  = 1'b0;
    end else if (m_live && cyc == m_resp_at) begin
      m_res = job_res;
      m_err = job_err;
    end
    e_gnt  = (m_live && cyc == m_gnt_at) ? (N'(1) << m_id) : '0;
    e_rv   = m_live && cyc == m_resp_at;
    e_busy = m_live && cyc >= m_gnt_at && cyc <= m_resp_at;
    chk("gnt",         64'(bus.gnt),         64'(e_gnt));
    chk("eng_go",      64'(bus.eng_go),      64'(e_gnt != '0));
    chk("resp_valid",  64'(bus.resp_valid),  64'(e_rv));
    chk("resp_id",     64'(bus.resp_id),     64'(e_rv ? m_id : 0));
    chk("resp_result", 64'(bus.resp_result), 64'(m_res));
    chk("resp_err",    64'(bus.resp_err),    64'(m_err));
    chk("busy",        64'(bus.busy),        64'(e_busy));
    chk("eng_data",    64'(bus.eng_data),    64'(m_data));
    // A new job starts whenever the scheduler is free and someone asks.
    if (!rst && (!m_live || cyc > m_resp_at) && bus.req != '0) begin
      int w;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_id     = w;
      m_ptr    = (w + 1) % N;
      m_data   = bus.req_data[w*WIDTH +: WIDTH];
      m_gnt_at = cyc + 1;
      m_live   = 1'b1;
      if (eng_hang) begin
        m_resp_at = cyc + TIMEOUT + 2;
        job_res   = '0;
        job_err   = 1'b1;
      end else begin
        m_resp_at = cyc + WIDTH + 3;
        job_res   = RW'(2*$countones(m_data) - WIDTH);
        job_err   = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int g = 0; g < 200; g++) begin
      tick();
      if (!m_live || cyc >= m_resp_at) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_wait", 64'(ok), 64'(1));
  endtask

  logic [WIDTH-1:0] dvals [3] = '{8'h00, 8'h0F, 8'h07};
  logic [RW-1:0]    dexp  [3] = '{5'b11000, 5'b00000, 5'b11110};

  initial begin
    logic [N-1:0] gl [3];
    int ng, last_c;
    bit raised;
    rst          = 1'b0;
    eng_hang     = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_eng_data", 64'(bus.eng_data), 64'(0));
    tick();
    rst = 1'b0;
    tick();

    // Single request, data changed after grant.
    bus.req = 4'b0100;
    bus.req_data[2*WIDTH +: WIDTH] = 8'hFF;
    tick();
    bus.req = '0;
    bus.req_data[2*WIDTH +: WIDTH] = 8'h00;
    @(negedge clk);
    chk("single_gnt", 64'(bus.gnt), 64'(4'b0100));
    tick();
    repeat (9) tick();
    @(negedge clk);
    chk("single_rv", 64'(bus.resp_valid), 64'(1));
    chk("single_id", 64'(bus.resp_id), 64'(2));
    chk("single_res", 64'(bus.resp_result), 64'(5'b01000));
    chk("single_err", 64'(bus.resp_err), 64'(0));
    tick();

    // Data table on requester 1.
    for (int j = 0; j < 3; j++) begin
      bus.req = 4'b0010;
      bus.req_data[1*WIDTH +: WIDTH] = dvals[j];
      tick();
      bus.req = '0;
      repeat (10) tick();
      @(negedge clk);
      chk("data_rv", 64'(bus.resp_valid), 64'(1));
      chk("data_res", 64'(bus.resp_result), 64'(dexp[j]));
      tick();
    end

    // Reset, then all four requesters held: 0,1,2,3,... every 12 cycles.
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();
    bus.req = '1;
    ng = 0;
    last_c = 0;
    for (int c = 0; c < 150 && ng < 8; c++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        chk("rr_order", 64'(bus.gnt), 64'(N'(1) << (ng % N)));
        if (ng > 0) chk("rr_spacing", 64'(c - last_c), 64'(12));
        last_c = c;
        ng++;
      end
    end
    chk("rr_count", 64'(ng), 64'(8));
    tick();
    bus.req = '0;
    wait_idle();

    // Fairness: req[3] continuous, req[1] raised mid-job.
    bus.req = 4'b1000;
    ng = 0;
    raised = 1'b0;
    for (int c = 0; c < 100 && ng < 3; c++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        gl[ng] = bus.gnt;
        ng++;
      end
      tick();
      if (ng >= 1 && !raised) begin
        bus.req[1] = 1'b1;
        raised = 1'b1;
      end
      if (bus.gnt[1]) bus.req[1] = 1'b0;
    end
    chk("fair_count", 64'(ng), 64'(3));
    chk("fair_g0", 64'(gl[0]), 64'(4'b1000));
    chk("fair_g1", 64'(gl[1]), 64'(4'b0010));
    chk("fair_g2", 64'(gl[2]), 64'(4'b1000));
    bus.req = '0;
    wait_idle();

    // Timeout with a hung engine, then a normal job.
    eng_hang = 1'b1;
    bus.req = 4'b0001;
    bus.req_data[0 +: WIDTH] = 8'hAA;
    tick();
    bus.req = '0;
    repeat (64) tick();
    @(negedge clk);
    chk("to_early", 64'(bus.resp_valid), 64'(0));
    tick();
    @(negedge clk);
    chk("to_rv", 64'(bus.resp_valid), 64'(1));
    chk("to_err", 64'(bus.resp_err), 64'(1));
    chk("to_res", 64'(bus.resp_result), 64'(0));
    tick();
    eng_hang = 1'b0;
    bus.req = 4'b0100;
    bus.req_data[2*WIDTH +: WIDTH] = 8'h01;
    tick();
    bus.req = '0;
    repeat (10) tick();
    @(negedge clk);
    chk("after_to_rv", 64'(bus.resp_valid), 64'(1));
    chk("after_to_res", 64'(bus.resp_result), 64'(5'b11010));
    chk("after_to_err", 64'(bus.resp_err), 64'(0));
    tick();

    // Reset during BUSY with requesters 1 and 3 pending.
    bus.req = 4'b0010;
    bus.req_data[1*WIDTH +: WIDTH] = 8'h3C;
    repeat (5) tick();
    bus.req = 4'b1010;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_gnt", 64'(bus.gnt), 64'(0));
    chk("rst_rv", 64'(bus.resp_valid), 64'(0));
    chk("rst_res", 64'(bus.resp_result), 64'(0));
    chk("rst_eng_data", 64'(bus.eng_data), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_regrant", 64'(bus.gnt), 64'(4'b0010));
    tick();
    bus.req = '0;
    wait_idle();

    // Randomized traffic; phase 2 runs with a hung engine.
    for (int ph = 0; ph < 4; ph++) begin
      eng_hang = (ph == 2);
      for (int c = 0; c < 250; c++) begin
        tick();
        for (int i = 0; i < N; i++) begin
          if (bus.gnt[i]) bus.req[i] = 1'b0;
          else if (!bus.req[i]) begin
            if ($urandom_range(0, 3) == 0) bus.req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            if ($urandom_range(0, 5) == 0) bus.req[i] = 1'b1;
          end
        end
      end
      bus.req = '0;
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, errors);
    $fatal(1);
  end
endmodule

// File: doc/bit_diff_sched.md
# bit_diff_sched

Round-robin scheduler that shares one bit-difference engine among `N` requesters. Each requester presents a data word and holds `req` high until it is granted. The scheduler captures the word and launches the engine with a one-cycle `go`. It then waits for the engine's `done`, returns the signed result tagged with the requester's index, and moves on to the next requester. A watchdog ends any job that never completes.

## Interface
- `N`, 4: number of requesters; must be ≥ 2.
- `WIDTH`, 8: data word width; must match the engine.
- `TIMEOUT`, 64: maximum cycles in BUSY before the job is aborted; must be > WIDTH+2.
- `RW` (localparam) = `$clog2(2*WIDTH+1)`: result width.
- `IW` (localparam) = `$clog2(N)`: requester index width.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  N  per-requester request level.
- `req_data`  in  N*WIDTH  requester i's word in bits [i*WIDTH +: WIDTH].
- `gnt`  out  N  one-hot grant pulse.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_id`  out  IW  index of the requester the response belongs to.
- `resp_result`  out  RW  signed result (count of 1s minus count of 0s).
- `resp_err`  out  1  set with `resp_valid` when the job timed out.
- `busy`  out  1  high whenever the state is not IDLE.
- `eng_go`  out  1  engine start strobe.
- `eng_data`  out  WIDTH  word presented to the engine.
- `eng_result`  in  RW  engine result.
- `eng_done`  in  1  engine done flag; sticky until the next `go` is accepted.

## Operation
- States and transitions:
  - IDLE: if `|req`, select the winner, capture `req_data[winner]` into `data_q` and the winner's index into `id_q`, then go to LAUNCH.
  - LAUNCH: one cycle, then go to BUSY.
  - BUSY: go to RESP on `eng_done`, or when `wd_cnt == TIMEOUT-1`.
  - RESP: one cycle, then go to IDLE.
- Arbitration is round-robin with pointer `ptr`.
  - The winner is the first set `req` bit scanning `ptr`, `ptr+1`, … modulo N.
  - On each grant, `ptr` becomes `winner+1` (mod N).
  - After reset `ptr` = 0.
- LAUNCH outputs:
  - `gnt[id_q]`=1 and `eng_go`=1 for exactly this cycle.
  - `eng_data`=`data_q` in every state; `data_q` changes only on capture in IDLE.
- Requester rule: drop `req` the cycle after seeing `gnt`. A `req` still high in IDLE is treated as a new job.
- BUSY:
  - `wd_cnt` clears on entry and increments each cycle.
  - On `eng_done`=1: register `resp_result`=`eng_result` and `resp_err`=0.
  - On timeout without done: `resp_result`=0 and `resp_err`=1. If `eng_done` and timeout occur in the same cycle, done wins.
- RESP: `resp_valid`=1 and `resp_id`=`id_q`. `resp_result` and `resp_err` hold until the next RESP.
- Engine contract: `done` is low on the cycle after `go` is sampled, so a stale `done` from the previous job is never seen in BUSY.
- Arithmetic: `resp_result` is passed through unmodified as an RW-bit two's-complement value; no sign extension or saturation.

## Timing
- Reset values:
  - `gnt`, `resp_valid`, `resp_id`, `resp_result`, `resp_err`, `busy`, `eng_go`, `eng_data` are all 0.
  - `ptr` = 0; state = IDLE.
- Reset mid-job: the state returns to IDLE immediately and no response is emitted. The engine shares `rst`.
- Request sampled in IDLE at cycle t:
  - `gnt` and `eng_go` at t+1.
  - The engine computes during t+2 … t+WIDTH+1.
  - `eng_done` rises at t+WIDTH+2.
  - `resp_valid` at t+WIDTH+3.
  - IDLE again at t+WIDTH+4.
- Throughput: one job per WIDTH+4 cycles while requests are pending.
- Timeout response: `resp_valid` at t+TIMEOUT+2.
- Requests arriving while not in IDLE wait; there is no queueing beyond the `req` level.
- `gnt` and `resp_valid` never assert in the same cycle.

## Test plan
- Single request, N=4, WIDTH=8: `req[2]`, data 8'hFF:
  - `gnt`=4'b0100 one cycle after the request is sampled.
  - `resp_valid` 11 cycles after the request is sampled, with `resp_id`=2, `resp_result`=+8, `resp_err`=0.
- Data values with real engine: 8'h00 → −8; 8'h0F → 0; 8'h07 → −2. Changing `req_data` after `gnt` does not affect the result.
- All four requesters held continuously:
  - Grants are 0,1,2,3,0,… spaced 12 cycles apart.
  - Each `resp_id` matches the preceding grant.
- Fairness: `req[3]` continuous and `req[1]` raised mid-job → the next grant goes to 1, then 3; neither requester is granted twice in a row while the other waits.
- Timeout: engine model never raises `done`, TIMEOUT=64 → `resp_valid` 66 cycles after the request is sampled, with `resp_err`=1 and `resp_result`=0; the scheduler then accepts the next request.
- Reset during BUSY:
  - All outputs are 0 and `busy`=0 in the same cycle, with no `resp_valid`.
  - After release, a pending `req[1]` is granted with `ptr`=0 priority.
